seq_event_counter: RTL
======================

# seq_event_counter

Downstream consumer of the serial run detector (four-equal-bits detector). It samples the detector's `out` every cycle, counts detection events (rising edges) and total detected cycles in saturating counters, and drives two active-low seven-segment digits showing the event count in hex for the board display.

## Interface
- `CNT_W`, default 8: width of both counters; must be ≥ 8.
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `det_out`  in  1  detector output, sampled every cycle; level, not a pulse.
- `clear`  in  1  synchronous counter clear, active-high.
- `evt_cnt`  out  CNT_W  number of rising edges of `det_out` seen, saturating.
- `cyc_cnt`  out  CNT_W  number of cycles with `det_out`=1, saturating.
- `evt_pulse`  out  1  one-cycle pulse, one cycle after each counted edge.
- `ovf`  out  1  sticky: an increment was attempted on either counter at max.
- `seg_lo`  out  8  hex digit of `evt_cnt[3:0]`; bit0=a … bit6=g, bit7=dp; active-low.
- `seg_hi`  out  8  hex digit of `evt_cnt[7:4]`; same encoding.

## Operation
- Internal `det_q`: `det_out` delayed one cycle. Edge = `det_out & ~det_q`.
- Edge cycle: `evt_cnt` += 1 unless at 2^CNT_W−1; if at max, hold and set `ovf`.
- Any cycle with `det_out`=1: `cyc_cnt` += 1 unless at max; at max hold and set `ovf`.
- A held-high `det_out` (detector staying in run state) produces exactly one event and one `cyc_cnt` increment per high cycle.
- `evt_pulse` registered: high in cycle N+1 iff edge in cycle N; never high two consecutive cycles.
- `clear`=1: `evt_cnt`, `cyc_cnt`, `ovf` load 0; `det_q` still updates; `evt_pulse` still reports an edge in that cycle (clear does not suppress pulse). Clear has priority over increment in the same cycle (result 0, not 1).
- `ovf` only cleared by `clear` or `reset`.
- Segment decode: purely combinational from `evt_cnt` register bits, standard hex glyphs 0–F (b,d lowercase), `dp` always off (bit7=1). Example: 0 → 8'b1100_0000, 1 → 8'b1111_1001, 8 → 8'b1000_0000, F → 8'b1000_1110.
- Counter bits above 7 not displayed.

## Timing
- Reset values: `det_q`=0, `evt_cnt`=0, `cyc_cnt`=0, `evt_pulse`=0, `ovf`=0, `seg_lo`=`seg_hi`=8'b1100_0000.
- Reset during a high `det_out` run: after deassert, `det_q`=0, so if `det_out` is still 1 in the first post-reset cycle it counts as a new event.
- Latency: `det_out` rises in cycle N → `evt_cnt`, `cyc_cnt`, `evt_pulse` updated/visible in cycle N+1; segs same cycle as `evt_cnt`.
- Wrap-around never occurs; saturation only.
- `clear` and `reset` both asserted: reset behaviour (all zero, `evt_pulse`=0).

## Test plan
- Reset: hold `reset` 2 cycles with `det_out`=1 → all outputs at reset values; release with `det_out`=1 → next cycle `evt_cnt`=1, `cyc_cnt`=1, `evt_pulse`=1.
- Run: `det_out` = 0,1,1,1,0,1,0 → final `evt_cnt`=2, `cyc_cnt`=4, `evt_pulse` high exactly twice, `ovf`=0.
- Display: drive 0x3A events (alternating 1/0) → `seg_hi`=8'b1011_0000 ("3"), `seg_lo`=8'b1000_1000 ("A").
- Saturation: 256 single-cycle events with CNT_W=8 → `evt_cnt`=255, `ovf`=1; further events leave `evt_cnt`=255, `evt_pulse` still pulses.
- Clear collision: `clear`=1 in the same cycle as an edge with `evt_cnt`=5 → next cycle `evt_cnt`=0, `cyc_cnt`=0, `ovf`=0, `evt_pulse`=1.
- Held high: `det_out`=1 for 10 cycles from 0 → `evt_cnt`=1, `cyc_cnt`=10.

Source files
------------

// File: rtl/seq_event_counter_if.sv
// Detector-to-counter bus: detector level and clear in, counters and display out.
interface seq_event_counter_if #(
  parameter int CNT_W = 8
) ();
  logic             det_out;
  logic             clear;
  logic [CNT_W-1:0] evt_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic             evt_pulse;
  logic             ovf;
  logic [7:0]       seg_lo;
  logic [7:0]       seg_hi;

  // Producer/consumer side: drives the detector level and clear.
  modport master (
    output det_out, clear,
    input  evt_cnt, cyc_cnt, evt_pulse, ovf, seg_lo, seg_hi
  );

  // Counter side.
  modport slave (
    input  det_out, clear,
    output evt_cnt, cyc_cnt, evt_pulse, ovf, seg_lo, seg_hi
  );
endinterface

// File: rtl/seq_event_counter.sv
// Counts detector events (rising edges) and high cycles with saturation,
// and shows the low byte of the event count on two active-low hex digits.
module seq_event_counter #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  seq_event_counter_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic             det_q;
  logic [CNT_W-1:0] evt_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic             evt_pulse;
  logic             ovf;
  logic             edge_det;
  logic             evt_sat;
  logic             cyc_sat;

  // Rising edge of the detector level; det_q is 0 after reset so a level
  // still high on release counts as a fresh event.
  assign edge_det = bus.det_out & ~det_q;
  assign evt_sat  = edge_det    & (evt_cnt == MAX);
  assign cyc_sat  = bus.det_out & (cyc_cnt == MAX);

  // Edge history, pulse and saturating counters; clear beats increment
  // but leaves the edge tracker and pulse running.
  always_ff @(posedge clk) begin
    if (reset) begin
      det_q     <= 1'b0;
      evt_pulse <= 1'b0;
      evt_cnt   <= '0;
      cyc_cnt   <= '0;
      ovf       <= 1'b0;
    end else begin
      det_q     <= bus.det_out;
      evt_pulse <= edge_det;
      if (bus.clear) begin
        evt_cnt <= '0;
        cyc_cnt <= '0;
        ovf     <= 1'b0;
      end else begin
        if (edge_det && !evt_sat)    evt_cnt <= evt_cnt + 1'b1;
        if (bus.det_out && !cyc_sat) cyc_cnt <= cyc_cnt + 1'b1;
        if (evt_sat || cyc_sat)      ovf     <= 1'b1;
      end
    end
  end

  // Active-low hex glyph, bit0=a .. bit6=g, dp (bit7) always off.
  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign bus.evt_cnt   = evt_cnt;
  assign bus.cyc_cnt   = cyc_cnt;
  assign bus.evt_pulse = evt_pulse;
  assign bus.ovf       = ovf;
  assign bus.seg_lo    = hex7(evt_cnt[3:0]);
  assign bus.seg_hi    = hex7(evt_cnt[7:4]);
endmodule
